// File: rtl/vz_decode_stage.sv
// vz16 instruction-decode stage: field split, class decode, register scoreboard
// with same-cycle writeback bypass, valid/ready output slot and hazard-stall counter.
module vz_decode_stage #(
   parameter int RW    = 4,
   parameter int NREGS = 13,
   parameter int AW    = 16
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4+3*RW-1:0]   in_instr,
   input  logic [AW-1:0]       in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4:0]          out_class,
   output logic [2:0]          out_alu_op,
   output logic                out_option,
   output logic [RW-1:0]       out_rd,
   output logic [RW-1:0]       out_rs1,
   output logic [RW-1:0]       out_rs2,
   output logic                out_wr_en,
   output logic                out_illegal,
   output logic [AW-1:0]       out_pc,
   input  logic                wb_valid,
   input  logic [RW-1:0]       wb_idx,
   output logic [NREGS-1:0]    busy,
   output logic [15:0]         stall_cnt
);

   function automatic logic f_oob(input logic [RW-1:0] idx);
      return int'({1'b0, idx}) >= NREGS;
   endfunction

   function automatic logic f_bit(input logic [NREGS-1:0] v, input logic [RW-1:0] idx);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NREGS; i++)
         if (idx == RW'(i)) r = v[i];
      return r;
   endfunction

   logic [RW-1:0]    w_rn, w_r1, w_r2, w_rd;
   logic             w_opt;
   logic [4:0]       w_class;
   logic [2:0]       w_alu_op;
   logic             w_use_r1, w_use_r2, w_use_rn, w_use_sp, w_wr_raw;
   logic             w_illegal, w_wr_en, w_hazard, w_accept;
   logic [NREGS-1:0] w_clr, w_busy_eff, w_busy_nxt;

   logic             r_out_valid;
   logic [4:0]       r_class;
   logic [2:0]       r_alu_op;
   logic             r_option, r_wr_en, r_illegal;
   logic [RW-1:0]    r_rd, r_rs1, r_rs2;
   logic [AW-1:0]    r_pc;
   logic [NREGS-1:0] r_busy;
   logic [15:0]      r_stall_cnt;

   // Decode: class, source usage and write intent straight from the instruction word
   always_comb begin
      w_rn     = in_instr[4 +: RW];
      w_r1     = in_instr[4+RW +: RW];
      w_r2     = in_instr[4+2*RW +: RW];
      w_opt    = in_instr[0];
      w_class  = 5'b00000;
      w_alu_op = 3'd0;
      w_use_r1 = 1'b0;
      w_use_r2 = 1'b0;
      w_use_rn = 1'b0;
      w_use_sp = 1'b0;
      w_wr_raw = 1'b0;
      w_rd     = w_rn;
      if (in_instr[3]) begin
         w_class  = 5'b00001;
         w_alu_op = in_instr[2:0];
         w_use_r1 = 1'b1;
         w_use_r2 = 1'b1;
         w_wr_raw = 1'b1;
      end else begin
         case (in_instr[2:1])
            2'b00: w_class = 5'b10000;
            2'b01: begin
               w_class  = 5'b00010;
               w_use_r1 = 1'b1;
               w_use_rn = w_opt;
               w_wr_raw = ~w_opt;
            end
            2'b10: begin
               w_class  = 5'b00100;
               w_use_sp = 1'b1;
               w_use_rn = w_opt;
               w_wr_raw = 1'b1;
               w_rd     = '0;
            end
            default: begin
               w_class  = 5'b01000;
               w_use_r1 = 1'b1;
               w_use_r2 = 1'b1;
               w_wr_raw = 1'b1;
            end
         endcase
      end
   end

   // Scoreboard view with writeback bypass, hazard and handshake
   always_comb begin
      for (int i = 0; i < NREGS; i++)
         w_clr[i] = wb_valid && (wb_idx == RW'(i));
      w_busy_eff = r_busy & ~w_clr;
      w_illegal  = (w_use_r1 & f_oob(w_r1)) | (w_use_r2 & f_oob(w_r2)) |
                   (w_use_rn & f_oob(w_rn)) | (w_wr_raw & f_oob(w_rd));
      w_wr_en    = w_wr_raw & ~w_illegal;
      w_hazard   = ~w_illegal & (
                   (w_use_r1 & f_bit(w_busy_eff, w_r1)) |
                   (w_use_r2 & f_bit(w_busy_eff, w_r2)) |
                   (w_use_rn & f_bit(w_busy_eff, w_rn)) |
                   (w_use_sp & w_busy_eff[0]) |
                   (w_wr_en  & f_bit(w_busy_eff, w_rd)));
      in_ready   = reset & ~flush & ~w_hazard & (~r_out_valid | out_ready);
      w_accept   = in_valid & in_ready;
      // A set on the same index as a clear wins, so it is applied after the clear
      w_busy_nxt = w_busy_eff;
      for (int i = 0; i < NREGS; i++)
         if (w_accept && w_wr_en && (w_rd == RW'(i))) w_busy_nxt[i] = 1'b1;
   end

   // Output slot, scoreboard and stall counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_class     <= '0;
         r_alu_op    <= '0;
         r_option    <= 1'b0;
         r_wr_en     <= 1'b0;
         r_illegal   <= 1'b0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_pc        <= '0;
         r_busy      <= '0;
         r_stall_cnt <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_busy      <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (in_valid && w_hazard && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_class     <= w_class;
            r_alu_op    <= w_alu_op;
            r_option    <= w_opt;
            r_wr_en     <= w_wr_en;
            r_illegal   <= w_illegal;
            r_rd        <= w_rd;
            r_rs1       <= w_r1;
            r_rs2       <= w_r2;
            r_pc        <= in_pc;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_class   = r_class;
   assign out_alu_op  = r_alu_op;
   assign out_option  = r_option;
   assign out_wr_en   = r_wr_en;
   assign out_illegal = r_illegal;
   assign out_rd      = r_rd;
   assign out_rs1     = r_rs1;
   assign out_rs2     = r_rs2;
   assign out_pc      = r_pc;
   assign busy        = r_busy;
   assign stall_cnt   = r_stall_cnt;

endmodule

// File: doc/vz_decode_stage.md
# vz_decode_stage

Parametrised instruction-decode pipeline stage for the vz16 CPU family, sitting between instruction fetch and execute. It splits each instruction word into class, ALU opcode, option bit and register fields, and holds the result in a valid/ready output register. A register scoreboard stalls issue on RAW/WAW hazards until writeback clears the pending destination. It generalises the original fixed 16-bit, 13-register decoder in field width, register count and PC width, and adds flow control, illegal-index detection and a stall counter.

## Interface
- RW, 4: register-index field width; instruction width IW = 4 + 3*RW.
- NREGS, 13: implemented registers (index 0 = sp); 2 <= NREGS <= 2**RW.
- AW, 16: PC width.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low.
- flush  in  1  discard output slot and clear scoreboard.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  IW  instruction word.
- in_pc  in  AW  PC of in_instr.
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  execute consumes.
- out_class  out  5  one-hot {sys, shift, stack, ls, alu}.
- out_alu_op  out  3  ALU opcode; 0 when not ALU.
- out_option  out  1  instr[0].
- out_rd, out_rs1, out_rs2  out  RW each  destination/source indices.
- out_wr_en  out  1  instruction writes out_rd.
- out_illegal  out  1  some used index >= NREGS.
- out_pc  out  AW  captured PC.
- wb_valid  in  1  writeback completes.
- wb_idx  in  RW  register written back.
- busy  out  NREGS  scoreboard bits.
- stall_cnt  out  16  saturating hazard-stall cycle count.

## Operation
- Fields: Rn = instr[4+RW-1:4], R1 = next RW bits, R2 = top RW bits.
- Class: instr[3]=1 -> alu, op = instr[2:0]; else instr[2:1]: 00 sys, 01 ls, 10 stack, 11 shift.
- out_rd = Rn, except stack: out_rd = 0 (sp). out_rs1 = R1, out_rs2 = R2.
- Write enables: alu, shift always; ls when option=0 (load); stack always (sp update). sys never.
- Sources checked: alu/shift R1,R2; ls R1, plus Rn when option=1 (store); stack reg 0, plus Rn when option=1 (push); sys none.
- Illegal: any used index (sources, destination) >= NREGS -> out_illegal=1, out_wr_en=0, no hazard check, no scoreboard set; still issues.
- Hazard: any checked source or the destination has busy set, evaluated on busy & ~clr, where clr = one-hot(wb_idx) when wb_valid (same-cycle writeback bypass).
- in_ready = reset & ~flush & ~hazard & (~out_valid | out_ready); combinational on in_instr.
- Accept (in_valid & in_ready): load all out_* fields, out_valid <= 1, busy[rd] <= 1 if out_wr_en.
- Drain without accept: out_valid <= 1 & ~out_ready; fields hold.
- Same cycle set and clear of one index: set wins. wb_valid with a non-busy or out-of-range wb_idx: ignored.
- flush: out_valid <= 0, busy <= 0, no accept that cycle; wb ignored.
- stall_cnt increments on cycles with in_valid & hazard & ~flush; saturates at 0xFFFF; not cleared by flush.

## Timing
- Reset (reset=0 at edge): out_valid=0, busy=0, stall_cnt=0, all out_* fields 0; in_ready=0 while reset low.
- Latency: accept at edge N -> out_valid high after edge N.
- Throughput: one instruction/cycle with out_ready held high and no hazards.
- Outputs stable while out_valid & ~out_ready.
- Writeback at edge N releases a dependent instruction in the same cycle (bypass); it issues at edge N.
- Reset mid-stall: all state cleared, pending instruction must be re-presented.

## Test plan
- Reset: hold reset=0 two cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0, stall_cnt=0.
- Decode: RW=4, instr 0x321A (alu, op 2, Rn=1, R1=2, R2=3) -> out_class=00001, out_alu_op=2, rd=1, rs1=2, rs2=3, out_wr_en=1, busy[1]=1.
- RAW: issue 0x321A, then 0x4518 (reads R1=5? use R2=1: 0x1528) -> in_ready=0, stall_cnt counts; wb_valid, wb_idx=1 -> accepted that cycle.
- Backpressure: out_ready=0 for 3 cycles with stream -> outputs hold, in_ready=0; release -> one instruction/cycle.
- Illegal: NREGS=13, Rn=14 alu -> out_illegal=1, out_wr_en=0, busy unchanged.
- Flush with busy=0x0006 and out_valid=1 -> next cycle out_valid=0, busy=0, stall_cnt unchanged.
